// File: rtl/tartaruga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tartaruga_pkg
// Description : Shared bus and cache-line types for the tartaruga core.
// Revision    : 1.0 - line types for the memory responder
// ============================================================================
package tartaruga_pkg;

    localparam int LINE_BITS        = 128;
    localparam int LINE_BYTES       = 16;
    localparam int LINE_OFFSET_BITS = 4;

    typedef logic [31:0]          bus32_t;
    typedef logic [LINE_BITS-1:0] line_t;

    // The data cache stores exactly what the memory side returns.
    typedef line_t cache_line_t;

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_ram
// Description : DEPTH x line_t storage, one synchronous write port and one
//               asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
module line_ram
    import tartaruga_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  line_t            wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output line_t            rd_data_o
);

    line_t r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder
// Description : Single-outstanding line read/write responder with a fixed
//               request-to-response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder
    import tartaruga_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   mem_req_valid_i,
    output logic   mem_req_ready_o,
    input  bus32_t mem_addr_i,
    input  logic   mem_we_i,
    input  line_t  mem_data_wr_i,
    output logic   mem_rsp_valid_o,
    input  logic   mem_rsp_ready_i,
    output line_t  mem_data_line_o,
    output bus32_t mem_rsp_addr_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] c_cnt_load = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    line_t            r_rsp_data;
    bus32_t           r_rsp_addr;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    line_t            w_rd_data;
    logic             w_unused_offset;

    assign w_accept        = (r_state == IDLE) && mem_req_valid_i;
    assign w_idx           = mem_addr_i[LINE_OFFSET_BITS +: IDX_W];
    assign w_unused_offset = ^mem_addr_i[LINE_OFFSET_BITS-1:0];

    line_ram #(
        .DEPTH     (DEPTH)
    ) u_line_ram (
        .clk_i     (clk_i),
        .we_i      (w_accept && mem_we_i),
        .wr_idx_i  (w_idx),
        .wr_data_i (mem_data_wr_i),
        .rd_idx_i  (w_idx),
        .rd_data_o (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (mem_req_valid_i) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                if (mem_rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Response data is captured at acceptance, so later writes cannot alter it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            r_rsp_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_rsp_data <= mem_we_i ? mem_data_wr_i : w_rd_data;
                r_rsp_addr <= {mem_addr_i[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            end
        end
    end

    assign mem_req_ready_o = (r_state == IDLE);
    assign mem_rsp_valid_o = (r_state == RESP);
    assign mem_data_line_o = r_rsp_data;
    assign mem_rsp_addr_o  = r_rsp_addr;

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Randomized and directed bench for line_mem_responder at
//               LATENCY 1, 2 and 5 against a line-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;
    import tartaruga_pkg::*;

    localparam int DEPTH = 256;
    localparam int N_DUT = 3;

    logic   clk = 1'b0;
    logic   rst;
    logic   mem_req_valid;
    logic   mem_we;
    logic   mem_rsp_ready;
    bus32_t mem_addr;
    line_t  mem_data_wr;

    logic   req_ready [N_DUT];
    logic   rsp_valid [N_DUT];
    line_t  data_line [N_DUT];
    bus32_t rsp_addr  [N_DUT];

    line_t  model_mem   [DEPTH];
    bit     model_known [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int c_lat = (g == 0) ? 1 : (g == 1) ? 2 : 5;
        line_mem_responder #(
            .DEPTH           (DEPTH),
            .LATENCY         (c_lat)
        ) u_dut (
            .clk_i           (clk),
            .rst_i           (rst),
            .mem_req_valid_i (mem_req_valid),
            .mem_req_ready_o (req_ready[g]),
            .mem_addr_i      (mem_addr),
            .mem_we_i        (mem_we),
            .mem_data_wr_i   (mem_data_wr),
            .mem_rsp_valid_o (rsp_valid[g]),
            .mem_rsp_ready_i (mem_rsp_ready),
            .mem_data_line_o (data_line[g]),
            .mem_rsp_addr_o  (rsp_addr[g])
        );
    end

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            default: return 5;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("%s_ready[lat%0d]", tag, lat_of(i)), 128'(req_ready[i]), 128'd1);
            check($sformatf("%s_valid[lat%0d]", tag, lat_of(i)), 128'(rsp_valid[i]), 128'd0);
            check($sformatf("%s_data[lat%0d]", tag, lat_of(i)), data_line[i], 128'd0);
            check($sformatf("%s_addr[lat%0d]", tag, lat_of(i)), 128'(rsp_addr[i]), 128'd0);
        end
    endtask

    task automatic drive_junk();
        bus32_t r;
        r             = $urandom();
        mem_req_valid = 1'b1;
        mem_we        = 1'($urandom_range(0, 1));
        mem_addr      = r;
        mem_data_wr   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Called at a negedge with every DUT idle; returns at the negedge of the
    // first cycle after the response handshake, where all DUTs are idle again.
    task automatic do_req(input logic we, input bus32_t addr, input line_t wdata,
                          input int hold, input bit junk);
        int     idx;
        int     r_cyc;
        bit     chk_data;
        bit     exp_v;
        line_t  exp_data;
        bus32_t exp_addr;

        idx      = int'(addr[4 +: 8]);
        exp_addr = {addr[31:4], 4'b0};
        if (we) begin
            model_mem[idx]   = wdata;
            model_known[idx] = 1'b1;
            exp_data         = wdata;
            chk_data         = 1'b1;
        end else begin
            exp_data = model_mem[idx];
            chk_data = model_known[idx];
        end
        r_cyc = 5 + hold;

        for (int i = 0; i < N_DUT; i++) begin
            check($sformatf("ready_idle[lat%0d]", lat_of(i)), 128'(req_ready[i]), 128'd1);
        end
        mem_rsp_ready = 1'b0;
        mem_req_valid = 1'b1;
        mem_we        = we;
        mem_addr      = addr;
        mem_data_wr   = wdata;
        @(posedge clk);

        for (int k = 1; k <= r_cyc + 1; k++) begin
            @(negedge clk);
            for (int i = 0; i < N_DUT; i++) begin
                exp_v = (k >= lat_of(i)) && (k <= r_cyc);
                check($sformatf("rsp_valid_c%0d[lat%0d]", k, lat_of(i)), 128'(rsp_valid[i]), 128'(exp_v));
                check($sformatf("req_ready_c%0d[lat%0d]", k, lat_of(i)), 128'(req_ready[i]), 128'(k == r_cyc + 1));
                if (exp_v) begin
                    check($sformatf("rsp_addr_c%0d[lat%0d]", k, lat_of(i)), 128'(rsp_addr[i]), 128'(exp_addr));
                    if (chk_data) begin
                        check($sformatf("rsp_data_c%0d[lat%0d]", k, lat_of(i)), data_line[i], exp_data);
                    end
                end
            end
            if (junk && k < r_cyc) begin
                drive_junk();
            end else begin
                mem_req_valid = 1'b0;
            end
            mem_rsp_ready = (k == r_cyc);
        end
    endtask

    task automatic reset_mid_read(input bus32_t addr);
        mem_rsp_ready = 1'b0;
        mem_req_valid = 1'b1;
        mem_we        = 1'b0;
        mem_addr      = addr;
        mem_data_wr   = '0;
        @(posedge clk);
        @(negedge clk);
        mem_req_valid = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("post_rst");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < N_DUT; i++) begin
                check($sformatf("no_rsp_c%0d[lat%0d]", k, lat_of(i)), 128'(rsp_valid[i]), 128'd0);
                check($sformatf("idle_c%0d[lat%0d]", k, lat_of(i)), 128'(req_ready[i]), 128'd1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus32_t r;
        int     idx;
        line_t  line_a;
        line_t  line_b;

        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b0;
        end
        rst           = 1'b1;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_rsp_ready = 1'b0;
        mem_addr      = '0;
        mem_data_wr   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Write then read of the same line through an unaligned address.
        do_req(1'b1, 32'h0000_0040, 128'h0123456789ABCDEF0123456789ABCDEF, 0, 1'b0);
        do_req(1'b0, 32'h0000_004C, '0, 0, 1'b0);

        // Index wraps modulo DEPTH lines; the upper address bits are echoed.
        do_req(1'b1, 32'h0000_0000, {4{32'hAAAA_AAAA}}, 1, 1'b0);
        do_req(1'b0, 32'h0000_1000, '0, 0, 1'b0);

        // Long backpressure with competing requests presented meanwhile.
        do_req(1'b0, 32'h0000_0040, '0, 7, 1'b1);

        // Snapshot: read old value, then overwrite, then read new value.
        line_a = {$urandom(), $urandom(), $urandom(), $urandom()};
        line_b = ~line_a;
        do_req(1'b1, 32'h0000_0030, line_a, 0, 1'b0);
        do_req(1'b0, 32'h0000_0030, '0, 2, 1'b1);
        do_req(1'b1, 32'h0000_0038, line_b, 0, 1'b0);
        do_req(1'b0, 32'h0000_0030, '0, 0, 1'b0);

        // Reset while a read is pending; array contents survive.
        reset_mid_read(32'h0000_0030);
        do_req(1'b0, 32'h0000_0030, '0, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            r   = $urandom();
            idx = $urandom_range(0, 15);
            r   = (r & 32'hFFFF_F00F) | (32'(idx) << 4);
            do_req(1'($urandom_range(0, 1)), r,
                   {$urandom(), $urandom(), $urandom(), $urandom()},
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
